// File: rtl/cache_sim_pkg.sv
// cache_sim_pkg: cache geometry helpers, prefetch-buffer entry type and FSM state encodings
package cache_sim_pkg;
    localparam int BLOCK_SIZE_BYTE = 16;
    localparam int CACHE_SIZE_BYTE = 32768;
    localparam int WAY = 1;
    function automatic int boff_w(input int bs);
        return $clog2(bs);
    endfunction
    function automatic int set_w(input int cs, input int bs, input int way);
        return $clog2(cs / (bs * way));
    endfunction
    localparam int BOFF_W = boff_w(BLOCK_SIZE_BYTE);
    localparam int SET_W = set_w(CACHE_SIZE_BYTE, BLOCK_SIZE_BYTE, WAY);
    localparam int ADDR_W = 32 - BOFF_W;
    localparam int TAG_W = ADDR_W - SET_W;
    localparam int DATA_W = BLOCK_SIZE_BYTE * 8;
    typedef logic [ADDR_W-1:0] block_addr_t;
    typedef struct packed {
        logic               valid;
        block_addr_t        addr;
        logic [DATA_W-1:0]  data;
    } pb_entry_t;
    typedef enum logic [1:0] {L_IDLE, L_CMP, L_RESP} lookup_state_t;
    typedef enum logic [1:0] {M_IDLE, M_REQ, M_FILL} mem_state_t;
endpackage

// File: rtl/pb_victim_select.sv
// pb_victim_select: picks the lowest invalid PB entry, else the round-robin pointer entry
module pb_victim_select #(parameter int N = 4) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] victim,
    output logic [$clog2(N)-1:0] ptr_next
);
    localparam int IW = $clog2(N);
    always_comb begin
        victim = ptr;
        for (int i = N - 1; i >= 0; i--)
            if (!valid[i]) victim = IW'(i);
        ptr_next = &valid ? ptr + 1'b1 : ptr;
    end
endmodule

// File: rtl/next_line_prefetcher.sv
// next_line_prefetcher: answers cache-miss lookups from a small prefetch buffer and fetches addr+1.
// Define PREFETCH_STATS_EN to add saturating issued/useful prefetch counters.
module next_line_prefetcher import cache_sim_pkg::*; #(parameter int PB_ENTRIES = 4) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid,
    input  logic [TAG_W-1:0]  tag,
    input  logic [SET_W-1:0]  index,
    output logic              prefetch_hit,
    output logic [DATA_W-1:0] prefetch_data,
    output logic              lookup_done,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]       pf_issued_cnt,
    output logic [15:0]       pf_useful_cnt
`endif
);
    localparam int IW = $clog2(PB_ENTRIES);
    pb_entry_t pb [PB_ENTRIES];
    lookup_state_t l_state, l_next;
    mem_state_t m_state, m_next;
    block_addr_t a_q, cand, pend, inflight;
    logic pend_v, hit_q, cmp_hit, cand_dup, cand_ok, issue;
    logic [IW-1:0] hit_way, cmp_way, victim, ptr, ptr_next;
    logic [PB_ENTRIES-1:0] valid_vec;
    logic [DATA_W-1:0] fill_data;
    pb_victim_select #(.N(PB_ENTRIES)) u_victim (
        .valid(valid_vec), .ptr(ptr), .victim(victim), .ptr_next(ptr_next)
    );
    always_comb begin
        valid_vec = '0;
        cmp_hit = 1'b0;
        cmp_way = '0;
        cand_dup = 1'b0;
        cand = a_q + 1'b1;
        for (int i = 0; i < PB_ENTRIES; i++) begin
            valid_vec[i] = pb[i].valid;
            if (pb[i].valid && pb[i].addr == a_q) begin
                cmp_hit = 1'b1;
                cmp_way = IW'(i);
            end
            if (pb[i].valid && pb[i].addr == cand) cand_dup = 1'b1;
        end
        // a candidate already buffered, in flight or queued is never fetched twice
        cand_ok = l_state == L_RESP && !cand_dup && !(m_state != M_IDLE && inflight == cand)
                  && !(pend_v && pend == cand);
        issue = m_state == M_IDLE && pend_v;
        l_next = l_state == L_IDLE ? (lookup_valid ? L_CMP : L_IDLE) :
                 l_state == L_CMP ? L_RESP : L_IDLE;
        m_next = m_state == M_IDLE ? (pend_v ? M_REQ : M_IDLE) :
                 m_state == M_REQ ? (mem_ack ? M_FILL : M_REQ) : M_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_state <= L_IDLE;
            m_state <= M_IDLE;
            a_q <= '0;
            hit_q <= 1'b0;
            hit_way <= '0;
            pend <= '0;
            pend_v <= 1'b0;
            inflight <= '0;
            fill_data <= '0;
            ptr <= '0;
            prefetch_hit <= 1'b0;
            prefetch_data <= '0;
            lookup_done <= 1'b0;
            mem_req <= 1'b0;
            mem_addr <= '0;
            for (int i = 0; i < PB_ENTRIES; i++) pb[i] <= '0;
        end else begin
            l_state <= l_next;
            m_state <= m_next;
            lookup_done <= l_state == L_RESP;
            prefetch_hit <= l_state == L_RESP && hit_q;
            if (l_state == L_IDLE && lookup_valid) a_q <= {tag, index};
            if (l_state == L_CMP) begin
                hit_q <= cmp_hit;
                hit_way <= cmp_way;
            end
            if (l_state == L_RESP && hit_q) begin
                prefetch_data <= pb[hit_way].data;
                pb[hit_way].valid <= 1'b0;
            end
            if (cand_ok) begin
                pend <= cand;
                pend_v <= 1'b1;
            end else if (issue) pend_v <= 1'b0;
            if (issue) begin
                mem_req <= 1'b1;
                mem_addr <= {pend, {BOFF_W{1'b0}}};
                inflight <= pend;
            end
            if (m_state == M_REQ && mem_ack) begin
                mem_req <= 1'b0;
                fill_data <= mem_data;
            end
            // placed after the invalidate so a fill to the same entry takes precedence
            if (m_state == M_FILL) begin
                pb[victim] <= '{valid: 1'b1, addr: inflight, data: fill_data};
                ptr <= ptr_next;
            end
        end
    end
`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_issued_cnt <= '0;
            pf_useful_cnt <= '0;
        end else begin
            if (issue && !(&pf_issued_cnt)) pf_issued_cnt <= pf_issued_cnt + 1'b1;
            if (l_state == L_RESP && hit_q && !(&pf_useful_cnt)) pf_useful_cnt <= pf_useful_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_next_line_prefetcher.sv
// tb_next_line_prefetcher: directed table, corner sequences and random lookups against a transaction model
module tb_next_line_prefetcher;
    import cache_sim_pkg::*;
    logic clk = 0, rst_n = 1, lookup_valid = 0, mem_ack = 0;
    logic [TAG_W-1:0] tag = '0;
    logic [SET_W-1:0] index = '0;
    logic [DATA_W-1:0] mem_data = '0, prefetch_data;
    logic prefetch_hit, lookup_done, mem_req, req_prev = 0;
    logic [31:0] mem_addr;
`ifdef PREFETCH_STATS_EN
    logic [15:0] pf_issued_cnt, pf_useful_cnt;
`endif
    int errors = 0, checks = 0, req_cnt = 0;

    always #5 clk = ~clk;

    next_line_prefetcher dut (
        .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .tag(tag), .index(index),
        .prefetch_hit(prefetch_hit), .prefetch_data(prefetch_data), .lookup_done(lookup_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
`ifdef PREFETCH_STATS_EN
        , .pf_issued_cnt(pf_issued_cnt), .pf_useful_cnt(pf_useful_cnt)
`endif
    );

    always @(negedge clk) begin
        if (mem_req && !req_prev) req_cnt++;
        req_prev = mem_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [27:0] a;
        logic        hit;
        logic        req;
        logic [31:0] maddr;
    } vec_t;
    vec_t tbl [14];

    logic        mv [4];
    logic [27:0] ma [4];
    int          mptr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] data_of(input logic [27:0] a);
        return {16'hBEEF, a, ~a, a ^ 28'h5A5A5A5, a + 28'h1234567};
    endfunction

    task automatic do_reset();
        lookup_valid = 0;
        mem_ack = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic lookup(input logic [27:0] a, input logic exp_hit);
        {tag, index} = a;
        lookup_valid = 1;
        tick();
        lookup_valid = 0;
        tick();
        check("done_early", lookup_done, 0);
        tick();
        check("lookup_done", lookup_done, 1);
        check("prefetch_hit", prefetch_hit, exp_hit);
        if (exp_hit) check("prefetch_data", prefetch_data, data_of(a));
    endtask

    task automatic expect_req(input logic exp, input logic [31:0] addr);
        for (int i = 0; i < 6 && !mem_req; i++) tick();
        check("mem_req", mem_req, exp);
        if (exp) check("mem_addr", mem_addr, addr);
    endtask

    task automatic serve(input logic [27:0] c, input int dly);
        repeat (dly) tick();
        check("req_hold", {mem_req, mem_addr}, {1'b1, c, 4'h0});
        mem_ack = 1;
        mem_data = data_of(c);
        tick();
        mem_ack = 0;
        check("req_drop", mem_req, 0);
        tick();
    endtask

    function automatic int mfind(input logic [27:0] a);
        for (int i = 0; i < 4; i++) if (mv[i] && ma[i] == a) return i;
        return -1;
    endfunction

    initial begin
        tbl[0]  = '{28'h0000100, 1'b0, 1'b1, 32'h00001010};
        tbl[1]  = '{28'h0000101, 1'b1, 1'b1, 32'h00001020};
        tbl[2]  = '{28'hFFFFFFF, 1'b0, 1'b1, 32'h00000000};
        tbl[3]  = '{28'h0000000, 1'b1, 1'b1, 32'h00000010};
        tbl[4]  = '{28'h0000200, 1'b0, 1'b1, 32'h00002010};
        tbl[5]  = '{28'h0000300, 1'b0, 1'b1, 32'h00003010};
        tbl[6]  = '{28'h0000400, 1'b0, 1'b1, 32'h00004010};
        tbl[7]  = '{28'h0000500, 1'b0, 1'b1, 32'h00005010};
        tbl[8]  = '{28'h0000200, 1'b0, 1'b0, 32'h00000000};
        tbl[9]  = '{28'h0000501, 1'b1, 1'b1, 32'h00005020};
        tbl[10] = '{28'h0000102, 1'b0, 1'b1, 32'h00001030};
        tbl[11] = '{28'h0000200, 1'b0, 1'b1, 32'h00002010};
        tbl[12] = '{28'h0000001, 1'b0, 1'b1, 32'h00000020};
        tbl[13] = '{28'h0000301, 1'b0, 1'b1, 32'h00003020};

        do_reset();
        check("rst_hit", prefetch_hit, 0);
        check("rst_done", lookup_done, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", prefetch_data, 0);

        for (int i = 0; i < 14; i++) begin
            lookup(tbl[i].a, tbl[i].hit);
            expect_req(tbl[i].req, tbl[i].maddr);
            if (tbl[i].req) serve(tbl[i].maddr[31:4], i % 3);
        end

        // newer candidates overwrite the pending one while memory is stalled
        do_reset();
        req_cnt = 0;
        lookup(28'h100, 0);
        expect_req(1, 32'h1010);
        lookup(28'h200, 0);
        lookup(28'h300, 0);
        check("stall_addr", {mem_req, mem_addr}, {1'b1, 32'h1010});
        serve(28'h101, 2);
        expect_req(1, 32'h3010);
        serve(28'h301, 0);
        tick();
        check("req_total", req_cnt, 2);
        lookup(28'h101, 1);
        expect_req(1, 32'h1020);
        serve(28'h102, 1);
        lookup(28'h301, 1);
        expect_req(1, 32'h3020);
        serve(28'h302, 0);
        lookup(28'h201, 0);
        expect_req(1, 32'h2020);
        serve(28'h202, 0);

        // reset while a request is outstanding
        do_reset();
        lookup(28'h100, 0);
        expect_req(1, 32'h1010);
        rst_n = 0;
        #1;
        check("rst_async_req", mem_req, 0);
        check("rst_async_addr", mem_addr, 0);
        tick();
        rst_n = 1;
        tick();
        mem_ack = 1;
        mem_data = data_of(28'h101);
        tick();
        mem_ack = 0;
        tick();
        tick();
        check("late_ack_req", mem_req, 0);
        lookup(28'h101, 0);
        expect_req(1, 32'h1020);
        serve(28'h102, 0);

        // random lookups against a transaction-level model of the buffer
        do_reset();
        for (int i = 0; i < 4; i++) mv[i] = 0;
        mptr = 0;
        for (int n = 0; n < 60; n++) begin
            logic [27:0] a, c;
            int h, v;
            a = ($urandom_range(0, 4) == 0) ? 28'hFFFFFFD + 28'($urandom_range(0, 2))
                                            : 28'h7000 + 28'($urandom_range(0, 11));
            h = mfind(a);
            lookup(a, h >= 0);
            if (h >= 0) mv[h] = 0;
            c = a + 28'h1;
            expect_req(mfind(c) < 0, {c, 4'h0});
            if (mfind(c) < 0) begin
                serve(c, $urandom_range(0, 3));
                v = -1;
                for (int i = 3; i >= 0; i--) if (!mv[i]) v = i;
                if (v < 0) begin
                    v = mptr;
                    mptr = (mptr + 1) % 4;
                end
                mv[v] = 1;
                ma[v] = c;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
